// File: rtl/stoper_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// stoper_ctrl_pkg
// Shared definitions for the stopwatch run-control sequencer:
//   - state_e        : FSM state encoding (also driven out on o_state)
//   - BCD_W          : width of the packed BCD time word
//   - DEB_CYCLES_DEF : default debounce length in clock cycles
//   - BTN_SS/BTN_LR  : indices of the two buttons in the internal button vector
// ---------------------------------------------------------------------------
package stoper_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  localparam int BCD_W          = 24;
  localparam int DEB_CYCLES_DEF = 50000;

  localparam int NUM_BTN = 2;
  localparam int BTN_SS  = 0;
  localparam int BTN_LR  = 1;

  // The stopwatch counter advances in RUN and LAP; a lap only freezes the display.
  function automatic logic state_counts(input state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stoper_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One push-button conditioning path: 2-FF synchronizer, level debouncer and
// rising-edge press pulse.
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset
//   i_btn   : raw asynchronous button level, active-high
//   o_press : one-cycle pulse on each accepted 0->1 debounced transition
// Parameters:
//   DEB_CYCLES : consecutive stable synced cycles needed to accept a change (>= 2)
//   DEB_W      : debounce counter width, 2**DEB_W > DEB_CYCLES
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  // Flip on the DEB_CYCLES-th consecutive cycle of disagreement.
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             deb_reg;
  logic             deb_next;
  logic             deb_d_reg;
  logic [DEB_W-1:0] cnt_reg;
  logic [DEB_W-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    deb_next = deb_reg;
    if (sync2_reg != deb_reg) begin
      if (cnt_reg == CNT_LAST) begin
        deb_next = sync2_reg;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + DEB_W'(1);
      end
    end
  end

  // Debounced level and its delayed copy reset to 1, so a button held through
  // reset must be released and pressed again before it produces a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      deb_reg   <= 1'b1;
      deb_d_reg <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= i_btn;
      sync2_reg <= sync1_reg;
      deb_reg   <= deb_next;
      deb_d_reg <= deb_reg;
      cnt_reg   <= cnt_next;
    end
  end

  assign o_press = deb_reg & ~deb_d_reg;

endmodule

// File: rtl/stoper_ctrl.sv
// ---------------------------------------------------------------------------
// stoper_ctrl
// Run-control sequencer for the stopwatch. Conditions the START/STOP and
// LAP/RESET buttons, runs the IDLE/RUN/PAUSE/LAP FSM, drives the stoper
// counter enable/clear and selects live or lap-frozen BCD time for display.
//   i_clk      : system clock
//   i_rst      : synchronous active-high reset
//   i_btn_ss   : raw START/STOP button (async, active-high)
//   i_btn_lr   : raw LAP/RESET button (async, active-high)
//   i_bcd_time : live BCD time from stoper
//   o_cnt_en   : counter enable (RUN, LAP)
//   o_cnt_clr  : one-cycle counter clear pulse
//   o_bcd_disp : registered BCD word for s7_display
//   o_blank    : display blank request
//   o_state    : current FSM state (debug)
// Optional build macro STOPER_CTRL_BLINK_EN: when defined, o_blank blinks the
// display in PAUSE using a BLINK_W-bit divider; otherwise o_blank is 0.
// ---------------------------------------------------------------------------
module stoper_ctrl
  import stoper_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = 16,
  parameter int BLINK_W    = 23
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_ss,
  input  logic             i_btn_lr,
  input  logic [BCD_W-1:0] i_bcd_time,
  output logic             o_cnt_en,
  output logic             o_cnt_clr,
  output logic [BCD_W-1:0] o_bcd_disp,
  output logic             o_blank,
  output logic [1:0]       o_state
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw[BTN_SS] = i_btn_ss;
  assign btn_raw[BTN_LR] = i_btn_lr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
      ) u_btn_debounce (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (btn_raw[gi]),
        .o_press (press[gi])
      );
    end
  endgenerate

  state_e           state_reg;
  state_e           state_next;
  logic             cnt_clr_reg;
  logic             cnt_clr_next;
  logic             lap_load;
  logic [BCD_W-1:0] lap_reg;
  logic [BCD_W-1:0] disp_reg;

  // START/STOP has priority: when both presses land in the same cycle the
  // LAP/RESET press is dropped.
  always_comb begin
    state_next   = state_reg;
    cnt_clr_next = 1'b0;
    lap_load     = 1'b0;
    if (press[BTN_SS]) begin
      case (state_reg)
        ST_IDLE:  state_next = ST_RUN;
        ST_RUN:   state_next = ST_PAUSE;
        ST_PAUSE: state_next = ST_RUN;
        ST_LAP:   state_next = ST_PAUSE;
        default:  state_next = ST_IDLE;
      endcase
    end else if (press[BTN_LR]) begin
      case (state_reg)
        ST_IDLE: begin
          cnt_clr_next = 1'b1;
        end
        ST_RUN: begin
          state_next = ST_LAP;
          lap_load   = 1'b1;
        end
        ST_LAP: begin
          state_next = ST_RUN;
        end
        ST_PAUSE: begin
          state_next   = ST_IDLE;
          cnt_clr_next = 1'b1;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Display mux keys off the registered state, so the selection follows one
  // edge after the state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      cnt_clr_reg <= 1'b0;
      lap_reg     <= '0;
      disp_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_clr_reg <= cnt_clr_next;
      if (lap_load) begin
        lap_reg <= i_bcd_time;
      end
      disp_reg <= (state_reg == ST_LAP) ? lap_reg : i_bcd_time;
    end
  end

  assign o_cnt_en   = state_counts(state_reg);
  assign o_cnt_clr  = cnt_clr_reg;
  assign o_bcd_disp = disp_reg;
  assign o_state    = state_reg;

`ifdef STOPER_CTRL_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt_reg;

  // Cleared on PAUSE entry so the blink cycle always starts with the display lit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt_reg <= '0;
    end else if ((state_next == ST_PAUSE) && (state_reg != ST_PAUSE)) begin
      blink_cnt_reg <= '0;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
    end
  end

  assign o_blank = (state_reg == ST_PAUSE) & blink_cnt_reg[BLINK_W-1];
`else
  assign o_blank = 1'b0;
`endif

endmodule

// File: tb/tb_stoper_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stoper_ctrl
// Self-checking bench for stoper_ctrl with DEB_CYCLES=4, DEB_W=4, BLINK_W=4.
// ---------------------------------------------------------------------------
module tb_stoper_ctrl;

  localparam int LAT = 7;  // press-to-state latency in edges for DEB_CYCLES=4

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_ss;
  logic        btn_lr;
  logic [23:0] bcd_time;
  logic        cnt_en;
  logic        cnt_clr;
  logic [23:0] bcd_disp;
  logic        blank;
  logic [1:0]  state;

  always #5 clk = ~clk;

  stoper_ctrl #(
    .DEB_CYCLES (4),
    .DEB_W      (4),
    .BLINK_W    (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn_ss   (btn_ss),
    .i_btn_lr   (btn_lr),
    .i_bcd_time (bcd_time),
    .o_cnt_en   (cnt_en),
    .o_cnt_clr  (cnt_clr),
    .o_bcd_disp (bcd_disp),
    .o_blank    (blank),
    .o_state    (state)
  );

  typedef struct {
    logic        ss;
    logic        lr;
    logic [23:0] bcd_press;
    logic [23:0] bcd_after;
    logic [1:0]  exp_state;
    logic        exp_en;
    int          exp_clr;
    logic [23:0] exp_disp;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic        en;
    int          clr;
    logic [23:0] disp;
  } exp_t;

  exp_t       sb_q[$];
  vec_t       vecs[15];
  int         checks   = 0;
  int         failures = 0;
  logic [1:0] cur_state;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic exp_blank(input logic [1:0] st, input int k);
`ifdef STOPER_CTRL_BLINK_EN
    return (st == 2'd2) ? ((k % 16) >= 8) : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one press, check exact latency, then release and check settled outputs.
  task automatic press_step(input int idx, input logic ss, input logic lr,
                            input logic [23:0] bcd_press, input logic [23:0] bcd_after,
                            input exp_t e);
    int   clr_seen;
    exp_t got;
    clr_seen = 0;
    @(negedge clk);
    bcd_time = bcd_press;
    btn_ss   = ss;
    btn_lr   = lr;
    sb_q.push_back(e);
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk);
      #1;
      clr_seen += int'(cnt_clr);
    end
    chk($sformatf("step%0d_state_before_latency", idx), state, cur_state);
    @(posedge clk);
    #1;
    clr_seen += int'(cnt_clr);
    if (sb_q.size() == 0) begin
      chk($sformatf("step%0d_scoreboard_empty", idx), 32'd1, 32'd0);
      return;
    end
    got = sb_q.pop_front();
    chk($sformatf("step%0d_state_at_latency", idx), state, got.st);
    chk($sformatf("step%0d_clr_at_latency", idx), cnt_clr, got.clr);
    bcd_time = bcd_after;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        clr_seen += int'(cnt_clr);
      end
      if (k == 3) begin
        btn_ss = 1'b0;
        btn_lr = 1'b0;
      end
      chk($sformatf("step%0d_blank_k%0d", idx, k), blank, exp_blank(got.st, k));
    end
    chk($sformatf("step%0d_state", idx), state, got.st);
    chk($sformatf("step%0d_cnt_en", idx), cnt_en, got.en);
    chk($sformatf("step%0d_clr_pulses", idx), clr_seen, got.clr);
    chk($sformatf("step%0d_disp", idx), bcd_disp, got.disp);
    $display("step %0d ss=%0d lr=%0d state=%0d en=%0d clr_pulses=%0d disp=%h",
             idx, ss, lr, state, cnt_en, clr_seen, bcd_disp);
    cur_state = got.st;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] bounce_pat;
    exp_t        e;

    vecs[0]  = '{1'b1, 1'b0, 24'h000000, 24'h000005, 2'd1, 1'b1, 0, 24'h000005};
    vecs[1]  = '{1'b0, 1'b1, 24'h001234, 24'h001300, 2'd3, 1'b1, 0, 24'h001234};
    vecs[2]  = '{1'b0, 1'b1, 24'h001300, 24'h001305, 2'd1, 1'b1, 0, 24'h001305};
    vecs[3]  = '{1'b1, 1'b0, 24'h001400, 24'h001400, 2'd2, 1'b0, 0, 24'h001400};
    vecs[4]  = '{1'b0, 1'b1, 24'h001400, 24'h000000, 2'd0, 1'b0, 1, 24'h000000};
    vecs[5]  = '{1'b0, 1'b1, 24'h000000, 24'h000000, 2'd0, 1'b0, 1, 24'h000000};
    vecs[6]  = '{1'b1, 1'b0, 24'h000000, 24'h000010, 2'd1, 1'b1, 0, 24'h000010};
    vecs[7]  = '{1'b0, 1'b1, 24'h000500, 24'h000600, 2'd3, 1'b1, 0, 24'h000500};
    vecs[8]  = '{1'b1, 1'b0, 24'h000700, 24'h000700, 2'd2, 1'b0, 0, 24'h000700};
    vecs[9]  = '{1'b1, 1'b0, 24'h000800, 24'h000800, 2'd1, 1'b1, 0, 24'h000800};
    vecs[10] = '{1'b1, 1'b1, 24'h000900, 24'h000950, 2'd2, 1'b0, 0, 24'h000950};
    vecs[11] = '{1'b1, 1'b0, 24'h001000, 24'h001000, 2'd1, 1'b1, 0, 24'h001000};
    vecs[12] = '{1'b0, 1'b1, 24'h002000, 24'h002100, 2'd3, 1'b1, 0, 24'h002000};
    vecs[13] = '{1'b1, 1'b1, 24'h002200, 24'h002300, 2'd2, 1'b0, 0, 24'h002300};
    vecs[14] = '{1'b1, 1'b0, 24'h002400, 24'h002400, 2'd1, 1'b1, 0, 24'h002400};

    // Reset: display must hold 0 even with a non-zero live time.
    rst      = 1'b1;
    btn_ss   = 1'b0;
    btn_lr   = 1'b0;
    bcd_time = 24'hABCDEF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state, 2'd0);
    chk("reset_cnt_en", cnt_en, 1'b0);
    chk("reset_cnt_clr", cnt_clr, 1'b0);
    chk("reset_disp", bcd_disp, 24'h000000);
    chk("reset_blank", blank, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    bcd_time = 24'h000000;
    repeat (10) @(posedge clk);
    cur_state = 2'd0;

    // Bounce rejection: high runs of 1 and 3 cycles, never 4.
    bounce_pat = 20'b10111010111010111010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn_ss = bounce_pat[i];
    end
    @(negedge clk);
    btn_ss = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("bounce_state", state, 2'd0);
    chk("bounce_cnt_en", cnt_en, 1'b0);
    $display("bounce pattern applied state=%0d en=%0d", state, cnt_en);

    // Table-driven presses.
    for (int v = 0; v < 15; v++) begin
      e.st   = vecs[v].exp_state;
      e.en   = vecs[v].exp_en;
      e.clr  = vecs[v].exp_clr;
      e.disp = vecs[v].exp_disp;
      press_step(v, vecs[v].ss, vecs[v].lr, vecs[v].bcd_press, vecs[v].bcd_after, e);
    end

    // SS held through a reset pulse: no press until released and pressed again.
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("held_reset_state", state, 2'd0);
    chk("held_reset_cnt_en", cnt_en, 1'b0);
    chk("held_reset_clr", cnt_clr, 1'b0);
    $display("ss held through reset state=%0d en=%0d", state, cnt_en);
    @(negedge clk);
    btn_ss = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("held_release_state", state, 2'd0);
    cur_state = 2'd0;
    e.st   = 2'd1;
    e.en   = 1'b1;
    e.clr  = 0;
    e.disp = 24'h000042;
    press_step(15, 1'b1, 1'b0, 24'h000040, 24'h000042, e);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
